// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port pixel memory between VGA scan-out reads and buffered host writes.
// Latency: rgb/hsync/vsync update 2 clk after each p_tick. A host write reaches memory at least 1 clk after acceptance.
// Backpressure: wr_ready drops while the write FIFO is full. Display reads are never stalled.
//
// Ports:
//   clk, reset                         clock and asynchronous active-high reset
//   p_tick, video_on, hsync_in,        timing inputs from vga_sync
//   vsync_in, pixel_x, pixel_y
//   wr_valid/wr_ready/wr_addr/wr_data  host write channel (valid/ready)
//   mem_addr/mem_we/mem_wdata          combinational memory command
//   mem_rdata                          memory read data, valid the cycle after the read
//   rgb, hsync, vsync                  registered colour and re-timed sync
//   drop_cnt                           saturating count of out-of-range host writes
module vram_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic [7:0]        drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // One extra bit so a full frame of exactly 2^ADDR_W pixels does not wrap to 0.
  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(H_RES * V_RES);

  // Host write FIFO. Pointers carry one wrap bit to tell full from empty.
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW:0]       r_wptr;
  logic [PW:0]       r_rptr;

  logic [PW:0]       w_used;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_in_range;
  logic              w_push;
  logic              w_pop;
  logic              w_disp;
  logic [ADDR_W-1:0] w_disp_addr;

  // Display pipeline state.
  logic              r_pend;
  logic              r_st_von;
  logic              r_st_hs;
  logic              r_st_vs;
  logic [DATA_W-1:0] r_rgb;
  logic              r_hs;
  logic              r_vs;
  logic [7:0]        r_drop;

  assign w_used     = r_wptr - r_rptr;
  assign w_full     = (w_used == (PW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_wptr == r_rptr);
  assign wr_ready   = !w_full;
  assign w_accept   = wr_valid && wr_ready;
  assign w_in_range = ({1'b0, wr_addr} < PIX_TOTAL);
  // Out-of-range writes complete the handshake but are never stored.
  assign w_push     = w_accept && w_in_range;

  // The scan-out read owns the memory in any ticked active cycle.
  assign w_disp      = p_tick && video_on;
  assign w_pop       = !w_disp && !w_empty;
  assign w_disp_addr = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_disp) begin
      mem_addr = w_disp_addr;
    end else if (!w_empty) begin
      mem_addr  = r_fifo_addr[r_rptr[PW-1:0]];
      mem_wdata = r_fifo_data[r_rptr[PW-1:0]];
      mem_we    = 1'b1;
    end
  end

  // FIFO storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[PW-1:0]] <= wr_addr;
      r_fifo_data[r_wptr[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_accept && !w_in_range && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  // Every tick, blank or not, is staged and produces an output update one clk
  // later, when the read data for that tick is on mem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= 1'b0;
      r_st_von <= 1'b0;
      r_st_hs  <= 1'b0;
      r_st_vs  <= 1'b0;
      r_rgb    <= '0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
    end else begin
      r_pend <= p_tick;
      if (p_tick) begin
        r_st_von <= video_on;
        r_st_hs  <= hsync_in;
        r_st_vs  <= vsync_in;
      end
      if (r_pend) begin
        r_rgb <= r_st_von ? mem_rdata : '0;
        r_hs  <= r_st_hs;
        r_vs  <= r_st_vs;
      end
    end
  end

  assign rgb      = r_rgb;
  assign hsync    = r_hs;
  assign vsync    = r_vs;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter.
// Inputs change 1 ns after each rising edge; outputs are sampled 1-2 ns after it.
// Expected values are hand-computed constants.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, video_on, hsync_in, vsync_in;
  logic [9:0]  pixel_x, pixel_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic [2:0]  rgb;
  logic        hsync, vsync;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int viol_cnt = 0;
  logic [18:0] last_addr = '0;
  logic [2:0]  last_data = '0;
  int we_snap;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .drop_cnt(drop_cnt)
  );

  // Log every memory write, and any write issued in a display slot.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt    <= we_cnt + 1;
      last_addr <= mem_addr;
      last_data <= mem_wdata;
      if (p_tick && video_on) viol_cnt <= viol_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; p_tick = 0; video_on = 0; hsync_in = 0; vsync_in = 0;
    pixel_x = 0; pixel_y = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; mem_rdata = 0;
    step(); step();
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hsync", 32'(hsync), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset = 1'b0;
    step();
    chk("rst_wr_ready", 32'(wr_ready), 1);

    // Display read at (5,2).
    p_tick = 1; video_on = 1; pixel_x = 10'd5; pixel_y = 10'd2; hsync_in = 1; vsync_in = 1;
    #1;
    chk("disp_addr", 32'(mem_addr), 1285);
    chk("disp_we", 32'(mem_we), 0);
    step();
    p_tick = 0; mem_rdata = 3'b101; hsync_in = 0; vsync_in = 0;
    #1;
    chk("disp_rgb_t1", 32'(rgb), 0);
    step();
    mem_rdata = 3'b000;
    chk("disp_rgb_t2", 32'(rgb), 5);
    chk("disp_hsync", 32'(hsync), 1);
    chk("disp_vsync", 32'(vsync), 1);
    step();
    chk("disp_rgb_hold", 32'(rgb), 5);

    // Blank tick: no read issued, outputs blank.
    p_tick = 1; video_on = 0; mem_rdata = 3'b111; hsync_in = 0; vsync_in = 0;
    #1;
    chk("blank_addr", 32'(mem_addr), 0);
    chk("blank_we", 32'(mem_we), 0);
    step();
    p_tick = 0;
    step();
    chk("blank_rgb", 32'(rgb), 0);
    chk("blank_hsync", 32'(hsync), 0);
    chk("blank_vsync", 32'(vsync), 0);

    // Continuous display slots starve writes; FIFO fills at 4.
    p_tick = 1; video_on = 1;
    we_snap = we_cnt;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = 19'(10 + i); wr_data = 3'(i);
      #1;
      chk("fill_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
      step();
    end
    chk("fill_no_we", 32'(we_cnt - we_snap), 0);
    p_tick = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_we", 32'(mem_we), 1);
      chk("drain_addr", 32'(mem_addr), 32'(10 + k));
      chk("drain_data", 32'(mem_wdata), 32'(k));
      if (k == 0) chk("drain_ready0", 32'(wr_ready), 0);
      if (k == 1) chk("drain_ready1", 32'(wr_ready), 1);
      step();
      if (k == 1) wr_valid = 0;
    end
    #1;
    chk("drain_empty", 32'(mem_we), 0);
    step();

    // Out-of-range then in-range write during blanking.
    video_on = 0; p_tick = 0;
    we_snap = we_cnt;
    wr_valid = 1; wr_addr = 19'd307200; wr_data = 3'b001;
    #1;
    chk("oor_ready", 32'(wr_ready), 1);
    step();
    wr_addr = 19'd307199; wr_data = 3'b011;
    #1;
    chk("no_bypass", 32'(mem_we), 0);
    step();
    wr_valid = 0;
    #1;
    chk("edge_we", 32'(mem_we), 1);
    chk("edge_addr", 32'(mem_addr), 307199);
    chk("edge_data", 32'(mem_wdata), 3);
    step(); step();
    chk("edge_drop", 32'(drop_cnt), 1);
    chk("edge_we_cnt", 32'(we_cnt - we_snap), 1);
    chk("edge_last_addr", 32'(last_addr), 307199);
    chk("edge_last_data", 32'(last_data), 3);

    // 300 out-of-range writes saturate drop_cnt.
    we_snap = we_cnt;
    wr_valid = 1; wr_addr = 19'd400000; wr_data = 3'b110;
    for (int i = 0; i < 300; i++) begin
      if (i == 253) chk("sat_mid", 32'(drop_cnt), 254);
      step();
    end
    wr_valid = 0;
    step();
    chk("sat_drop", 32'(drop_cnt), 255);
    chk("sat_no_we", 32'(we_cnt - we_snap), 0);

    // Reset mid-operation with 3 queued writes and non-zero outputs.
    p_tick = 1; video_on = 1; hsync_in = 1; vsync_in = 1; mem_rdata = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 19'(20 + i); wr_data = 3'b010;
      step();
    end
    wr_valid = 0;
    step();
    chk("pre_rst_rgb", 32'(rgb), 7);
    we_snap = we_cnt;
    reset = 1'b1;
    #1;
    chk("mid_rst_rgb", 32'(rgb), 0);
    chk("mid_rst_hsync", 32'(hsync), 0);
    chk("mid_rst_vsync", 32'(vsync), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    p_tick = 0; video_on = 0; hsync_in = 0; vsync_in = 0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(wr_ready), 1);
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_no_we", 32'(we_cnt - we_snap), 0);
    wr_valid = 1; wr_addr = 19'd30; wr_data = 3'b100;
    step();
    wr_valid = 0;
    #1;
    chk("post_rst_we", 32'(mem_we), 1);
    chk("post_rst_addr", 32'(mem_addr), 30);
    step();

    chk("we_in_disp", 32'(viol_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
